de2_state_indicator: RTL

- Consumes the 3-bit system-state code written by the Nios II into the de2_state PIO output port; sits directly downstream of that PIO.
- Drives DE2 red/green LEDs and HEX0.
- On every state change: flashes the green LEDs for a fixed number of ticks, then shows a per-state LEDR animation.
- Fully synchronous, one clock domain (shared with the PIO).

---
 rtl/de2_state_indicator.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/de2_state_indicator.sv
// DE2 board state indicator: shows the Nios II system-state code on HEX0,
// flashes the green LEDs after every state change, then runs a per-state
// red LED animation. Single clock domain, shared with the de2_state PIO.
module de2_state_indicator #(
  parameter int unsigned TICK_DIV    = 2500000,
  parameter int unsigned FLASH_TICKS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  state_in,
  output logic [17:0] ledr,
  output logic [8:0]  ledg,
  output logic [6:0]  hex0,
  output logic        state_changed,
  output logic        busy
);

  localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned FlashW = $clog2(FLASH_TICKS + 1);

  localparam logic [TickW-1:0]  TickLast  = TickW'(TICK_DIV - 1);
  localparam logic [FlashW-1:0] FlashLast = FlashW'(FLASH_TICKS - 1);
  localparam logic [4:0]        PosMax    = 5'd17;

  typedef enum logic {StShow, StFlash} fsm_e;
  typedef enum logic {DirLeft, DirRight} dir_e;

  logic [TickW-1:0]  tick_cnt;
  logic              tick;
  logic              heartbeat;
  logic [2:0]        state_q;
  logic [2:0]        state_cur;
  fsm_e              fsm;
  logic [FlashW-1:0] flash_cnt;
  logic              flash_phase;
  logic [4:0]        pos;
  dir_e              dir;
  logic [17:0]       anim_cnt;

  logic [17:0]       ledr_d;
  logic [8:0]        ledg_d;
  logic [6:0]        hex0_d;

  // Active-low seven-segment decode, bit order g..a.
  function automatic logic [6:0] hex_decode(input logic [2:0] s);
    logic [6:0] seg;
    case (s)
      3'd0:    seg = 7'b1000000;
      3'd1:    seg = 7'b1111001;
      3'd2:    seg = 7'b0100100;
      3'd3:    seg = 7'b0110000;
      3'd4:    seg = 7'b0011001;
      3'd5:    seg = 7'b0010010;
      3'd6:    seg = 7'b0000010;
      default: seg = 7'b1111000;
    endcase
    return seg;
  endfunction

  assign tick = (tick_cnt == TickLast);

  // Free-running animation tick divider and heartbeat, independent of the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt  <= '0;
      heartbeat <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TickW'(1);
      if (tick) begin
        heartbeat <= ~heartbeat;
      end
    end
  end

  // Input register: the only place state_in is sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= 3'd0;
    end else begin
      state_q <= state_in;
    end
  end

  // Mode FSM plus animation position state. A state mismatch wins over a tick
  // in both modes, so a change during FLASH restarts the flash cleanly.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm           <= StShow;
      state_cur     <= 3'd0;
      flash_cnt     <= '0;
      flash_phase   <= 1'b0;
      state_changed <= 1'b0;
      busy          <= 1'b0;
      pos           <= 5'd0;
      dir           <= DirLeft;
      anim_cnt      <= 18'd0;
    end else begin
      state_changed <= 1'b0;
      if (state_q != state_cur) begin
        state_cur     <= state_q;
        flash_cnt     <= '0;
        flash_phase   <= 1'b1;
        state_changed <= 1'b1;
        fsm           <= StFlash;
        busy          <= 1'b1;
      end else if (tick) begin
        case (fsm)
          StFlash: begin
            flash_phase <= ~flash_phase;
            flash_cnt   <= flash_cnt + FlashW'(1);
            if (flash_cnt == FlashLast) begin
              fsm      <= StShow;
              busy     <= 1'b0;
              pos      <= 5'd0;
              dir      <= DirLeft;
              anim_cnt <= 18'd0;
            end
          end
          default: begin
            case (state_cur)
              3'd2: pos <= (pos == PosMax) ? 5'd0 : pos + 5'd1;
              3'd3: pos <= (pos == 5'd0) ? PosMax : pos - 5'd1;
              3'd4: begin
                // Bounce without dwelling twice on either end.
                if (dir == DirLeft) begin
                  if (pos == PosMax) begin
                    dir <= DirRight;
                    pos <= PosMax - 5'd1;
                  end else begin
                    pos <= pos + 5'd1;
                  end
                end else begin
                  if (pos == 5'd0) begin
                    dir <= DirLeft;
                    pos <= 5'd1;
                  end else begin
                    pos <= pos - 5'd1;
                  end
                end
              end
              3'd7: anim_cnt <= anim_cnt + 18'd1;
              default: ;
            endcase
          end
        endcase
      end
    end
  end

  // Next LED/HEX patterns from the current mode and animation state.
  always_comb begin
    ledr_d = 18'd0;
    ledg_d = {heartbeat, 8'h00};
    hex0_d = hex_decode(state_cur);
    if (fsm == StFlash) begin
      ledg_d[7:0] = {8{flash_phase}};
    end else begin
      ledg_d[2:0] = state_cur;
      case (state_cur)
        3'd0:    ledr_d = 18'd0;
        3'd1:    ledr_d = {18{1'b1}};
        3'd2,
        3'd3,
        3'd4:    ledr_d = 18'd1 << pos;
        3'd5:    ledr_d = {18{heartbeat}};
        3'd6:    ledr_d = {{9{~heartbeat}}, {9{heartbeat}}};
        default: ledr_d = anim_cnt;
      endcase
    end
  end

  // Output registers; nothing reaches a pin combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      ledr <= 18'd0;
      ledg <= 9'd0;
      hex0 <= 7'b1000000;
    end else begin
      ledr <= ledr_d;
      ledg <= ledg_d;
      hex0 <= hex0_d;
    end
  end

endmodule
